// File: rtl/psum_pkg.sv
// Shared types and saturating-add helper for the partial-sum accumulator.
package psum_pkg;

  typedef logic signed [3:0] dec_t;

  localparam int ACC_W = 16;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef struct packed {
    logic signed [ACC_W-1:0] sum;
    logic                    ovf;
  } sat_t;

  // One guard bit is enough because a single contribution is far below the accumulator range.
  function automatic sat_t sat_add(input logic signed [ACC_W-1:0] acc,
                                   input logic signed [ACC_W:0]   contrib);
    logic signed [ACC_W:0] nxt;
    sat_t                  r;
    nxt   = {acc[ACC_W-1], acc} + contrib;
    r.ovf = nxt[ACC_W] ^ nxt[ACC_W-1];
    if (!r.ovf)          r.sum = nxt[ACC_W-1:0];
    else if (nxt[ACC_W]) r.sum = ACC_MIN;
    else                 r.sum = ACC_MAX;
    return r;
  endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// One channel: sum across macros, apply bit-significance shift, saturating accumulate, result register.
module psum_acc_lane
  import psum_pkg::*;
#(
  parameter int MACRO_NUM = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [MACRO_NUM-1:0][3:0]     data_i,
  input  logic [2:0]                    shift_i,
  input  logic                          accept_i,
  input  logic                          last_i,
  output logic signed [ACC_W-1:0]       result_o,
  output logic                          ovf_o
);

  localparam int MSUM_W = 4 + $clog2(MACRO_NUM);
  localparam int SH_W   = MSUM_W + 7;

  logic signed [MSUM_W-1:0] msum;
  logic signed [SH_W-1:0]   shifted;
  logic signed [ACC_W:0]    contrib;
  logic signed [ACC_W-1:0]  acc_q, acc_d, res_q, res_d;
  sat_t                     sat;

  always_comb begin
    msum = '0;
    for (int m = 0; m < MACRO_NUM; m++) begin
      msum = msum + MSUM_W'(dec_t'(data_i[m]));
    end
    shifted = SH_W'(msum) <<< shift_i;
    contrib = (ACC_W+1)'(shifted);
    sat     = sat_add(acc_q, contrib);
    acc_d   = acc_q;
    res_d   = res_q;
    if (accept_i) begin
      if (last_i) begin
        res_d = sat.sum;
        acc_d = '0;
      end else begin
        acc_d = sat.sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign result_o = res_q;
  assign ovf_o    = sat.ovf;

endmodule

// File: rtl/psum_accumulator.sv
// Frame-level control for the per-channel accumulator lanes plus the valid/ready output register.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int CHANNEL_NUM = 128,
  parameter int MACRO_NUM   = 4,
  parameter int ACC_WIDTH   = ACC_W,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [CHANNEL_NUM-1:0][MACRO_NUM-1:0][3:0] data_in,
  input  logic [2:0]                             shift_in,
  input  logic                                   last_in,
  input  logic                                   valid_in,
  output logic                                   ready_in,
  output logic [CHANNEL_NUM-1:0][ACC_WIDTH-1:0]  data_out,
  output logic [CNT_WIDTH-1:0]                   beats_out,
  output logic                                   ovf_out,
  output logic                                   valid_out,
  input  logic                                   ready_out
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_base, cnt_inc;
  logic [CNT_WIDTH-1:0] beats_q, beats_d;
  logic                 sticky_q, sticky_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;
  logic                 accept, any_ovf;
  logic [CHANNEL_NUM-1:0] lane_ovf;

  assign ready_in = !valid_q || ready_out;
  assign accept   = valid_in && ready_in;
  assign any_ovf  = |lane_ovf;

  for (genvar k = 0; k < CHANNEL_NUM; k++) begin : g_lane
    psum_acc_lane #(.MACRO_NUM(MACRO_NUM)) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .data_i   (data_in[k]),
      .shift_i  (shift_in),
      .accept_i (accept),
      .last_i   (last_in),
      .result_o (data_out[k]),
      .ovf_o    (lane_ovf[k])
    );
  end

  // Beat counter saturates so very long frames still report a sane (pinned) count.
  always_comb begin
    cnt_base = (state_q == IDLE) ? '0 : cnt_q;
    cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);
    state_d  = state_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    beats_d  = beats_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q && !ready_out;
    if (accept) begin
      if (last_in) begin
        state_d  = IDLE;
        cnt_d    = '0;
        sticky_d = 1'b0;
        beats_d  = cnt_inc;
        ovf_d    = sticky_q | any_ovf;
        valid_d  = 1'b1;
      end else begin
        state_d  = ACCUM;
        cnt_d    = cnt_inc;
        sticky_d = sticky_q | any_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      beats_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      beats_q  <= beats_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign beats_out = beats_q;
  assign ovf_out   = ovf_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator.
module tb_psum_accumulator;

  localparam int CH = 128;
  localparam int MC = 4;
  localparam int AW = 16;
  localparam int CW = 8;

  logic                       clk = 1'b0;
  logic                       rstn;
  logic [CH-1:0][MC-1:0][3:0] data_in;
  logic [2:0]                 shift_in;
  logic                       last_in;
  logic                       valid_in;
  logic                       ready_in;
  logic [CH-1:0][AW-1:0]      data_out;
  logic [CW-1:0]              beats_out;
  logic                       ovf_out;
  logic                       valid_out;
  logic                       ready_out;

  int total = 0;
  int bad   = 0;

  psum_accumulator #(
    .CHANNEL_NUM(CH), .MACRO_NUM(MC), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .data_in   (data_in),
    .shift_in  (shift_in),
    .last_in   (last_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .beats_out (beats_out),
    .ovf_out   (ovf_out),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input int exp);
    for (int k = 0; k < CH; k++) begin
      chk(tag, int'($signed(data_out[k])), exp);
    end
  endtask

  task automatic set_data(input int v);
    for (int k = 0; k < CH; k++)
      for (int m = 0; m < MC; m++)
        data_in[k][m] = 4'(v);
  endtask

  task automatic beat(input int v, input int sh, input bit last);
    set_data(v);
    shift_in = 3'(sh);
    last_in  = last;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    rstn      = 1'b0;
    valid_in  = 1'b0;
    last_in   = 1'b0;
    shift_in  = '0;
    ready_out = 1'b1;
    set_data(0);
    #12;
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_beats", int'(beats_out), 0);
    chk("rst_ovf", int'(ovf_out), 0);
    chk("rst_ready_in", int'(ready_in), 1);
    chk_data("rst_data", 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // single-beat frame
    beat(1, 0, 1'b1);
    chk("single_valid", int'(valid_out), 1);
    chk_data("single_data", 4);
    chk("single_beats", int'(beats_out), 1);
    chk("single_ovf", int'(ovf_out), 0);
    idle();
    chk("single_drained", int'(valid_out), 0);

    // bit-serial frame: 4 + 8 + 16
    beat(1, 0, 1'b0);
    beat(1, 1, 1'b0);
    chk("serial_not_yet", int'(valid_out), 0);
    beat(1, 2, 1'b1);
    chk("serial_valid", int'(valid_out), 1);
    chk_data("serial_data", 28);
    chk("serial_beats", int'(beats_out), 3);
    idle();

    // eight beats of -4096 land exactly on the minimum
    for (int i = 0; i < 8; i++) beat(-8, 7, i == 7);
    chk_data("neg8_data", -32768);
    chk("neg8_beats", int'(beats_out), 8);
    chk("neg8_ovf", int'(ovf_out), 0);
    idle();
    for (int i = 0; i < 9; i++) beat(-8, 7, i == 8);
    chk_data("neg9_data", -32768);
    chk("neg9_beats", int'(beats_out), 9);
    chk("neg9_ovf", int'(ovf_out), 1);
    idle();
    beat(1, 0, 1'b1);
    chk("after_ovf_clear", int'(ovf_out), 0);
    chk_data("after_ovf_data", 4);
    idle();

    // backpressure
    ready_out = 1'b0;
    beat(2, 0, 1'b1);
    chk("bp_valid", int'(valid_out), 1);
    chk_data("bp_data", 8);
    chk("bp_ready_in", int'(ready_in), 0);
    beat(1, 0, 1'b0);
    chk("bp_hold_valid", int'(valid_out), 1);
    chk_data("bp_hold_data", 8);
    chk("bp_hold_beats", int'(beats_out), 1);
    ready_out = 1'b1;
    beat(3, 0, 1'b1);
    chk("bp_reload_valid", int'(valid_out), 1);
    chk_data("bp_reload_data", 12);
    chk("bp_reload_beats", int'(beats_out), 1);
    idle();
    chk("bp_drained", int'(valid_out), 0);

    // reset mid-frame
    beat(1, 0, 1'b0);
    beat(1, 0, 1'b0);
    rstn = 1'b0;
    #1;
    chk_data("midrst_data", 0);
    chk("midrst_valid", int'(valid_out), 0);
    chk("midrst_beats", int'(beats_out), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    beat(1, 0, 1'b1);
    chk_data("postrst_data", 4);
    chk("postrst_beats", int'(beats_out), 1);
    idle();

    // beat counter saturation
    for (int i = 0; i < 300; i++) beat(0, 0, 1'b0);
    beat(0, 0, 1'b1);
    chk("cnt_sat_beats", int'(beats_out), 255);
    chk_data("cnt_sat_data", 0);
    idle();

    // per-channel independence
    for (int k = 0; k < CH; k++)
      for (int m = 0; m < MC; m++)
        data_in[k][m] = 4'(k % 8);
    shift_in = 3'd0;
    last_in  = 1'b1;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    for (int k = 0; k < CH; k++) begin
      chk("chan_indep", int'($signed(data_out[k])), 4 * (k % 8));
    end
    chk("chan_indep_beats", int'(beats_out), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
